pixel_byte_cache: RTL and testbench



---
 rtl/pixel_byte_cache_if.sv | 11 +
 rtl/pixel_byte_cache.sv | 109 ++++++++++
 tb/tb_pixel_byte_cache.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_byte_cache_if.sv
// Pixel request/response bundle between edge_search (master) and the pixel byte cache (slave).
interface pixel_byte_cache_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       flush;
   logic       ready;
   logic       pixel;

   modport master (output x, y, flush, input ready, pixel);
   modport slave  (input x, y, flush, output ready, pixel);
endinterface

// File: rtl/pixel_byte_cache.sv
// Direct-mapped, one-byte-per-line read cache turning (x,y) pixel requests into
// image_memory byte reads; hits resolve combinationally, misses run one fill at a time.
module pixel_byte_cache #(
   parameter int ENTRIES    = 16,
   parameter int RD_LATENCY = 1,
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480
) (
   input  logic              clk,
   input  logic              reset,
   pixel_byte_cache_if.slave req,
   output logic [15:0]       rdaddress,
   input  logic [7:0]        rdata,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);
   localparam int IDXW = $clog2(ENTRIES);
   localparam logic [15:0] ROW_BYTES = 16'(WIDTH / 8);

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;
   state_t state, state_nxt;

   logic [ENTRIES-1:0]       valid;
   logic [ENTRIES-1:0][15:0] tag;
   logic [ENTRIES-1:0][7:0]  data;
   logic [15:0]              fill_addr;
   logic [2:0]               wait_cnt;
   logic                     abort;

   logic                     in_frame, hit, miss;
   logic [15:0]              baddr;
   logic [IDXW-1:0]          idx, fill_idx;
   logic                     start_fill, capture;

   assign in_frame = (int'(req.x) < WIDTH) && (int'(req.y) < HEIGHT);
   assign baddr    = 16'(req.y) * ROW_BYTES + 16'(req.x[9:3]);
   assign idx      = baddr[IDXW-1:0];
   assign fill_idx = fill_addr[IDXW-1:0];
   // Tag holds the whole byte address, so a tag match alone identifies the byte.
   assign hit      = in_frame && valid[idx] && (tag[idx] == baddr);
   assign miss     = in_frame && !hit;

   // Out-of-frame pixels resolve immediately as background.
   assign req.ready = !in_frame || hit;
   assign req.pixel = hit && data[idx][req.x[2:0]];

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (miss) state_nxt = FETCH;
         FETCH:   if (wait_cnt == 3'd1) state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_fill = (state == IDLE) && miss;
      capture    = (state == CAPTURE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdaddress <= '0;
         fill_addr <= '0;
         wait_cnt  <= '0;
      end else if (start_fill) begin
         rdaddress <= baddr;
         fill_addr <= baddr;
         wait_cnt  <= 3'(RD_LATENCY);
      end else if (state == FETCH) begin
         wait_cnt  <= wait_cnt - 3'd1;
      end
   end

   // A flush while a fill is outstanding means its byte may be from the old frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         abort <= 1'b0;
      else if (capture)                   abort <= 1'b0;
      else if (req.flush && state == FETCH) abort <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   valid <= '0;
      else if (req.flush)           valid <= '0;
      else if (capture && !abort)   valid[fill_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         tag[fill_idx]  <= fill_addr;
         data[fill_idx] <= rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && hit_count != 16'hFFFF)         hit_count  <= hit_count + 16'd1;
         if (start_fill && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_pixel_byte_cache.sv
// Bench for pixel_byte_cache: directed pixel/fill scenarios plus randomized traffic
// compared every cycle against a cache-directory model built from the frame memory.
module tb_pixel_byte_cache;
   localparam int ENTRIES    = 16;
   localparam int RD_LATENCY = 1;
   localparam int WIDTH      = 640;
   localparam int HEIGHT     = 480;
   localparam int NBYTES     = WIDTH * HEIGHT / 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rdaddress, hit_count, miss_count;
   logic [7:0]  rdata;
   logic [7:0]  mem [NBYTES];

   pixel_byte_cache_if bus();

   pixel_byte_cache #(.ENTRIES(ENTRIES), .RD_LATENCY(RD_LATENCY), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk(clk), .reset(reset), .req(bus), .rdaddress(rdaddress), .rdata(rdata),
      .hit_count(hit_count), .miss_count(miss_count));

   always #5 clk = ~clk;

   // image_memory with a one-edge read latency
   always @(posedge clk) rdata <= (int'(rdaddress) < NBYTES) ? mem[rdaddress] : 8'h00;

   int npass = 0;
   int ntot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
      else npass++;
   endtask

   // Reference model: which byte address each line holds, plus the one outstanding fill.
   bit mv [ENTRIES];
   int mtag [ENTRIES];
   bit busy, aborted;
   int fill_b, fill_end, cyc, m_rd, m_hits, m_miss;

   function automatic bit in_frame_f(input int xx, input int yy);
      return xx < WIDTH && yy < HEIGHT;
   endfunction
   function automatic int baddr_f(input int xx, input int yy);
      return yy * (WIDTH / 8) + xx / 8;
   endfunction
   function automatic bit model_hit(input int xx, input int yy);
      int b;
      b = baddr_f(xx, yy);
      return in_frame_f(xx, yy) && mv[b % ENTRIES] && mtag[b % ENTRIES] == b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
      busy = 0; aborted = 0; cyc = 0; m_rd = 0; m_hits = 0; m_miss = 0;
   endtask

   task automatic model_step();
      int xx, yy, b;
      bit h, was_busy;
      xx = int'(bus.x); yy = int'(bus.y);
      b = baddr_f(xx, yy);
      h = model_hit(xx, yy);
      was_busy = busy;
      if (h && m_hits < 65535) m_hits++;
      if (bus.flush) begin
         for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
         if (was_busy) aborted = 1;
      end
      if (was_busy) begin
         if (cyc == fill_end) begin
            if (!aborted) begin mv[fill_b % ENTRIES] = 1'b1; mtag[fill_b % ENTRIES] = fill_b; end
            busy = 0;
         end
      end else if (in_frame_f(xx, yy) && !h) begin
         busy = 1; aborted = 0; fill_b = b; m_rd = b;
         fill_end = cyc + RD_LATENCY + 1;
         if (m_miss < 65535) m_miss++;
      end
      cyc++;
   endtask

   task automatic compare();
      int xx, yy;
      bit h, exp_pix;
      logic [7:0] byte_v;
      xx = int'(bus.x); yy = int'(bus.y);
      h = model_hit(xx, yy);
      exp_pix = 1'b0;
      if (h) begin byte_v = mem[baddr_f(xx, yy)]; exp_pix = byte_v[xx % 8]; end
      chk("ready", 32'(bus.ready), 32'(!in_frame_f(xx, yy) || h));
      chk("pixel", 32'(bus.pixel), 32'(exp_pix));
      chk("rdaddress", 32'(rdaddress), 32'(m_rd));
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
   endtask

   always @(negedge clk) begin
      if (!reset) model_clear();
      compare();
      if (reset) model_step();
   end

   task automatic set_req(input int xx, input int yy);
      bus.x = 10'(xx);
      bus.y = 10'(yy);
   endtask

   task automatic wait_ready(input string name);
      for (int n = 0; n < 20 && !bus.ready; n++) @(negedge clk);
      chk(name, 32'(bus.ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; bus.flush = 1'b0;
      set_req(0, 0);
      for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
      mem[160] = 8'h80; mem[176] = 8'h01; mem[240] = 8'h08; mem[321] = 8'h02; mem[400] = 8'h20;

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 0);
      chk("rst_pixel", 32'(bus.pixel), 0);
      chk("rst_rdaddr", 32'(rdaddress), 0);
      chk("rst_hits", 32'(hit_count), 0);
      chk("rst_miss", 32'(miss_count), 0);
      set_req(700, 0);
      #1 chk("rst_oof_ready", 32'(bus.ready), 1);
      @(posedge clk); #1 reset = 1'b1;

      // first request misses and resolves three cycles later
      @(posedge clk); #1 set_req(7, 2);
      @(negedge clk); chk("t1_miss", 32'(bus.ready), 0);
      @(negedge clk); chk("t1_rdaddr", 32'(rdaddress), 160); chk("t1_wait1", 32'(bus.ready), 0);
      @(negedge clk); chk("t1_wait2", 32'(bus.ready), 0);
      @(negedge clk); chk("t1_ready", 32'(bus.ready), 1); chk("t1_pixel", 32'(bus.pixel), 1);
      chk("t1_miss_cnt", 32'(miss_count), 1);

      @(posedge clk); #1 set_req(6, 2);
      @(negedge clk); chk("t2_ready", 32'(bus.ready), 1); chk("t2_pixel", 32'(bus.pixel), 0);
      chk("t2_rdaddr", 32'(rdaddress), 160); chk("t2_hits", 32'(hit_count), 1);
      @(negedge clk); chk("t2_hits_inc", 32'(hit_count), 2);

      @(posedge clk); #1 set_req(9, 4);
      @(negedge clk); chk("t3a_miss", 32'(bus.ready), 0);
      @(negedge clk); chk("t3a_rdaddr", 32'(rdaddress), 321);
      wait_ready("t3a_ready"); chk("t3a_pixel", 32'(bus.pixel), 1);
      @(posedge clk); #1 set_req(3, 3);
      @(negedge clk); @(negedge clk); chk("t3b_rdaddr", 32'(rdaddress), 240);
      wait_ready("t3b_ready"); chk("t3b_pixel", 32'(bus.pixel), 1);
      @(posedge clk); #1 set_req(700, 10);
      @(negedge clk); chk("oofx_ready", 32'(bus.ready), 1); chk("oofx_pixel", 32'(bus.pixel), 0);
      @(posedge clk); #1 set_req(10, 500);
      @(negedge clk); chk("oofy_ready", 32'(bus.ready), 1); chk("oofy_pixel", 32'(bus.pixel), 0);
      @(negedge clk); chk("oof_rdaddr", 32'(rdaddress), 240); chk("oof_miss", 32'(miss_count), 3);

      // bytes 160 and 176 share line 0
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 set_req((i % 2 == 0) ? 7 : 128, 2);
         @(negedge clk); chk("t4_miss", 32'(bus.ready), 0);
         wait_ready("t4_ready"); chk("t4_pixel", 32'(bus.pixel), 1);
      end
      chk("t4_miss_cnt", 32'(miss_count), 7);

      // flush during FETCH
      @(posedge clk); #1 set_req(5, 5);
      @(posedge clk); #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      @(negedge clk);
      @(negedge clk); chk("t5_refetch", 32'(bus.ready), 0);
      wait_ready("t5_ready"); chk("t5_pixel", 32'(bus.pixel), 1); chk("t5_miss", 32'(miss_count), 9);

      // flush coinciding with CAPTURE
      @(posedge clk); #1 set_req(9, 4);
      @(posedge clk); #1;
      @(posedge clk); #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      @(negedge clk); chk("tc_refetch", 32'(bus.ready), 0);
      wait_ready("tc_ready"); chk("tc_pixel", 32'(bus.pixel), 1); chk("tc_miss", 32'(miss_count), 11);

      // reset mid-FETCH
      @(posedge clk); #1 set_req(3, 3);
      @(posedge clk); #2 reset = 1'b0;
      #1 chk("rf_ready", 32'(bus.ready), 0); chk("rf_miss", 32'(miss_count), 0);
      chk("rf_rdaddr", 32'(rdaddress), 0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); chk("rf_miss_again", 32'(bus.ready), 0);
      wait_ready("rf_ready2"); chk("rf_pixel", 32'(bus.pixel), 1); chk("rf_miss_cnt", 32'(miss_count), 1);

      // randomized traffic over a small working set with occasional flushes
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 9))
               0:       set_req($urandom_range(640, 1023), $urandom_range(0, 1023));
               1:       set_req($urandom_range(0, 1023), $urandom_range(480, 1023));
               default: set_req($urandom_range(0, 63), $urandom_range(0, 3));
            endcase
         end
         bus.flush = ($urandom_range(0, 39) == 0);
      end

      // hold a hit long enough to saturate the hit counter
      @(posedge clk); #1 bus.flush = 1'b0; set_req(7, 2);
      repeat (65600) @(posedge clk);
      @(negedge clk); chk("sat_hits", 32'(hit_count), 32'hFFFF);
      @(negedge clk); chk("sat_hold", 32'(hit_count), 32'hFFFF);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
